hr_nt_lane_serializer: RTL

// Parametrised DIN_W:LANES serializer. Generational successor to the fixed 16:4 half-rate mux.

---
 rtl/hr_mux_pkg.sv | 15 +
 rtl/ser_lane_shreg.sv | 30 +++
 rtl/hr_nt_lane_serializer.sv | 78 +++++++
 3 files changed

// File: rtl/hr_mux_pkg.sv
// Shared constants and elaboration helpers for the DIN_W:LANES lane serializer.
package hr_mux_pkg;

  localparam logic [15:0] IDLE_PAT_DEFAULT = 16'hAAAA;

  // Phase counter width; RATIO is at least 2, so the counter is never narrower than one bit.
  function automatic int ratio_w(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/ser_lane_shreg.sv
// One lane's shift register: loads its word slice at the load slot and presents one bit per advance.
module ser_lane_shreg #(
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [RATIO-1:0] slice,
  output logic             sym
);

  logic [RATIO-1:0] sh;

  // The bit presented now is the one dout captures on the next advancing edge.
  assign sym = (MSB_FIRST != 0) ? sh[RATIO-1] : sh[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
    end else if (load) begin
      sh <= slice;
    end else if (advance) begin
      if (MSB_FIRST != 0) sh <= {sh[RATIO-2:0], 1'b0};
      else                sh <= {1'b0, sh[RATIO-1:1]};
    end
  end

endmodule

// File: rtl/hr_nt_lane_serializer.sv
// DIN_W:LANES single-clock serializer with ready/valid word intake, idle-pattern fill and frame marker.
module hr_nt_lane_serializer
  import hr_mux_pkg::*;
#(
  parameter int               DIN_W     = 16,
  parameter int               LANES     = 4,
  parameter int               MSB_FIRST = 0,
  parameter logic [DIN_W-1:0] IDLE_PAT  = DIN_W'(IDLE_PAT_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [LANES-1:0] lane_en,
  input  logic             clr_status,
  output logic [LANES-1:0] dout,
  output logic             frame,
  output logic             underflow
);

  localparam int RATIO = DIN_W / LANES;
  localparam int CW    = ratio_w(RATIO);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  if ((DIN_W % LANES) != 0) begin : g_bad_width
    $error("DIN_W must be a multiple of LANES");
  end
  if (!is_pow2(RATIO) || (RATIO < 2)) begin : g_bad_ratio
    $error("DIN_W/LANES must be a power of two and at least 2");
  end

  // Handshake: a word moves when din_valid and din_ready are both high on a clk edge.
  // din_ready is high only in the load slot (last phase, en high, not in reset); the
  // slot loads either din or the idle pattern, so the lanes never starve.
  logic [CW-1:0]    cnt;
  logic             slot;
  logic [DIN_W-1:0] word_sel;
  logic [LANES-1:0] lane_bit;

  assign slot      = en & (cnt == CNT_LAST);
  assign din_ready = slot & ~rst;
  assign word_sel  = din_valid ? din : IDLE_PAT;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ser_lane_shreg #(
      .RATIO     (RATIO),
      .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .load    (slot),
      .advance (en),
      .slice   (word_sel[i*RATIO +: RATIO]),
      .sym     (lane_bit[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= CNT_LAST;
      dout      <= '0;
      frame     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (en) begin
        cnt   <= cnt + CW'(1);
        dout  <= lane_bit & lane_en;
        frame <= (cnt == '0);
      end
      // A missed slot outranks a simultaneous clear so no underflow is ever lost.
      if (slot && !din_valid) underflow <= 1'b1;
      else if (clr_status)    underflow <= 1'b0;
    end
  end

endmodule
